// File: rtl/grid_checker.sv
// Streaming Sudoku-style grid checker: consumes LENGTH*LENGTH one-hot cells in
// row-major order and reports whether every row, column and block is a permutation.
module grid_checker #(
  parameter int ORDER = 3,
  localparam int LENGTH = ORDER * ORDER,
  localparam int AREA = LENGTH * LENGTH,
  localparam int IW = $clog2(AREA)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_value,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [IW-1:0]     err_index
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int BW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(AREA - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LENGTH - 1);
  localparam logic [BW-1:0] LAST_SUB = BW'(ORDER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_one_hot(input logic [LENGTH-1:0] v);
    return (v != {LENGTH{1'b0}}) && ((v & (v - LENGTH'(1))) == {LENGTH{1'b0}});
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ready;
  logic              r_busy;
  logic              w_in_ready_nxt;
  logic              w_busy_nxt;
  logic              r_done;
  logic              r_success;
  logic [IW-1:0]     r_err_index;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     r_row;
  logic [BW-1:0]     r_bcol;
  logic [BW-1:0]     r_brow;
  logic [BW-1:0]     r_col_in_blk;
  logic [BW-1:0]     r_row_in_blk;
  logic              r_err_flag;
  logic [IW-1:0]     r_first_err;
  logic [LENGTH-1:0] r_row_seen [LENGTH];
  logic [LENGTH-1:0] r_col_seen [LENGTH];
  logic [LENGTH-1:0] r_blk_seen [LENGTH];
  logic [CW-1:0]     w_blk;
  logic [LENGTH-1:0] w_seen;
  logic              w_offence;
  logic              w_accept;
  logic              w_last;
  logic              w_err_final;
  logic [IW-1:0]     w_err_pos;

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign success   = r_success;
  assign err_index = r_err_index;

  // Cell classification: start wins over a same-cycle handshake.
  always_comb begin
    w_accept    = (r_state == ST_RECV) && in_valid && !start;
    w_last      = w_accept && (r_idx == LAST_IDX);
    w_blk       = CW'(r_brow) * CW'(ORDER) + CW'(r_bcol);
    w_seen      = r_row_seen[r_row] | r_col_seen[r_col] | r_blk_seen[w_blk];
    w_offence   = !is_one_hot(in_value) || ((in_value & w_seen) != {LENGTH{1'b0}});
    w_err_final = r_err_flag || w_offence;
    w_err_pos   = r_err_flag ? r_first_err : r_idx;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_RECV;
        else       w_next_state = ST_IDLE;
      end
      ST_RECV: begin
        if (start)       w_next_state = ST_RECV;
        else if (w_last) w_next_state = ST_DONE;
        else             w_next_state = ST_RECV;
      end
      ST_DONE: begin
        if (start) w_next_state = ST_RECV;
        else       w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the flops track the state.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    case (w_next_state)
      ST_RECV: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      ST_IDLE, ST_DONE: begin
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
      default: begin
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Position counters, seen-bitmaps, first-error capture and result latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx        <= {IW{1'b0}};
      r_col        <= {CW{1'b0}};
      r_row        <= {CW{1'b0}};
      r_bcol       <= {BW{1'b0}};
      r_brow       <= {BW{1'b0}};
      r_col_in_blk <= {BW{1'b0}};
      r_row_in_blk <= {BW{1'b0}};
      r_err_flag   <= 1'b0;
      r_first_err  <= {IW{1'b0}};
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_err_index  <= {IW{1'b0}};
      for (int i = 0; i < LENGTH; i++) begin
        r_row_seen[i] <= {LENGTH{1'b0}};
        r_col_seen[i] <= {LENGTH{1'b0}};
        r_blk_seen[i] <= {LENGTH{1'b0}};
      end
    end else if (start) begin
      r_idx        <= {IW{1'b0}};
      r_col        <= {CW{1'b0}};
      r_row        <= {CW{1'b0}};
      r_bcol       <= {BW{1'b0}};
      r_brow       <= {BW{1'b0}};
      r_col_in_blk <= {BW{1'b0}};
      r_row_in_blk <= {BW{1'b0}};
      r_err_flag   <= 1'b0;
      r_first_err  <= {IW{1'b0}};
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_err_index  <= {IW{1'b0}};
      for (int i = 0; i < LENGTH; i++) begin
        r_row_seen[i] <= {LENGTH{1'b0}};
        r_col_seen[i] <= {LENGTH{1'b0}};
        r_blk_seen[i] <= {LENGTH{1'b0}};
      end
    end else if (w_accept) begin
      r_idx             <= r_idx + IW'(1);
      r_row_seen[r_row] <= r_row_seen[r_row] | in_value;
      r_col_seen[r_col] <= r_col_seen[r_col] | in_value;
      r_blk_seen[w_blk] <= r_blk_seen[w_blk] | in_value;
      if (w_offence && !r_err_flag) begin
        r_err_flag  <= 1'b1;
        r_first_err <= r_idx;
      end
      // End of a row resets the column side and steps the row side of the block position.
      if (r_col == LAST_COL) begin
        r_col        <= {CW{1'b0}};
        r_bcol       <= {BW{1'b0}};
        r_col_in_blk <= {BW{1'b0}};
        r_row        <= (r_row == LAST_COL) ? {CW{1'b0}} : r_row + CW'(1);
        if (r_row_in_blk == LAST_SUB) begin
          r_row_in_blk <= {BW{1'b0}};
          r_brow       <= (r_brow == LAST_SUB) ? {BW{1'b0}} : r_brow + BW'(1);
        end else begin
          r_row_in_blk <= r_row_in_blk + BW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
        if (r_col_in_blk == LAST_SUB) begin
          r_col_in_blk <= {BW{1'b0}};
          r_bcol       <= r_bcol + BW'(1);
        end else begin
          r_col_in_blk <= r_col_in_blk + BW'(1);
        end
      end
      if (w_last) begin
        r_done      <= 1'b1;
        r_success   <= !w_err_final;
        r_err_index <= w_err_final ? w_err_pos : {IW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_grid_checker.sv
// Directed bench for grid_checker (ORDER=3): valid, erroring, reset and abort scenarios.
module tb_grid_checker;

  logic       clock;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_value;
  logic       busy;
  logic       done;
  logic       success;
  logic [6:0] err_index;

  int         n_tests;
  int         n_fail;
  int         hs;
  logic [8:0] grid [81];

  grid_checker #(.ORDER(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .busy      (busy),
    .done      (done),
    .success   (success),
    .err_index (err_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_valid();
    logic [8:0] one;
    one = 9'd1;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        grid[r*9+c] = one << ((3*(r%3) + r/3 + c) % 9);
      end
    end
  endtask

  task automatic do_start();
    @(negedge clock);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Sends cells 0..n-1 of grid; toggle gives the 1,0,0 valid pattern.
  task automatic feed(input int n, input bit toggle);
    int   k;
    int   idx;
    logic acc;
    k   = 0;
    idx = 0;
    hs  = 0;
    while (idx < n && k < 2000) begin
      in_valid = toggle ? (k % 3 == 0) : 1'b1;
      in_value = grid[idx];
      acc      = in_valid && in_ready;
      if (idx == 80 && acc) check("done_before_last", 32'(done), 32'd0);
      @(negedge clock);
      if (acc) begin
        idx++;
        hs++;
      end
      k++;
    end
    in_valid = 1'b0;
    check("feed_count", 32'(idx), 32'(n));
  endtask

  task automatic check_result(input string tag, input logic exp_succ, input logic [6:0] exp_err);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_success"}, 32'(success), 32'(exp_succ));
    check({tag, "_err_index"}, 32'(err_index), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check({tag, "_done_hold"}, 32'(done), 32'd1);
    check({tag, "_success_hold"}, 32'(success), 32'(exp_succ));
    check({tag, "_err_hold"}, 32'(err_index), 32'(exp_err));
  endtask

  task automatic run_grid(input string tag, input logic exp_succ, input logic [6:0] exp_err);
    do_start();
    feed(81, 1'b0);
    check_result(tag, exp_succ, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    hs       = 0;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_value = 9'd0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_success", 32'(success), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Valid grid, continuous valid.
    build_valid();
    do_start();
    check("recv_busy", 32'(busy), 32'd1);
    check("recv_in_ready", 32'(in_ready), 32'd1);
    feed(81, 1'b0);
    check_result("valid", 1'b1, 7'd0);

    // Valid grid with stalls; start also clears the previous result.
    do_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_success", 32'(success), 32'd0);
    feed(81, 1'b1);
    check("toggle_handshakes", 32'(hs), 32'd81);
    check_result("toggle", 1'b1, 7'd0);

    build_valid();
    grid[1]  = grid[0];
    grid[30] = grid[29];
    grid[50] = grid[49];
    run_grid("rowdup", 1'b0, 7'd1);

    build_valid();
    grid[9] = grid[0];
    run_grid("coldup", 1'b0, 7'd9);

    build_valid();
    grid[10] = grid[0];
    run_grid("blkdup", 1'b0, 7'd10);

    build_valid();
    grid[40] = 9'b0;
    run_grid("zero", 1'b0, 7'd40);

    build_valid();
    grid[40] = 9'b000000011;
    run_grid("multihot", 1'b0, 7'd40);

    build_valid();
    grid[80] = grid[79];
    run_grid("lastdup", 1'b0, 7'd80);

    // Reset in the middle of a grid.
    build_valid();
    do_start();
    feed(37, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd0);
    check("postrst_done", 32'(done), 32'd0);
    run_grid("afterrst", 1'b1, 7'd0);

    // Abort an erroring grid at cell 20; the colliding cell must be dropped.
    build_valid();
    grid[1] = grid[0];
    do_start();
    feed(20, 1'b0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_value = grid[20];
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    build_valid();
    feed(81, 1'b0);
    check_result("abort", 1'b1, 7'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_checker.md
GRID_CHECKER -- requirements
Module: grid_checker

Interface
REQ-001 Parameter ORDER, default 3; block side length.
REQ-002 Derived constant LENGTH = ORDER*ORDER; symbols per row, column and block.
REQ-003 Derived constant AREA = LENGTH*LENGTH; cells per grid.
REQ-004 Derived constant IW = clog2(AREA); width of the cell index.
REQ-005 Port clock, input, 1 bit; single clock, all logic on its rising edge.
REQ-006 Port reset, input, 1 bit; asynchronous, active-low.
REQ-007 Port start, input, 1 bit; begins a new check of one grid.
REQ-008 Port in_valid, input, 1 bit; in_value holds a cell.
REQ-009 Port in_ready, output, 1 bit; checker accepts a cell this cycle.
REQ-010 Port in_value, input, LENGTH bits; one-hot symbol of the current cell.
REQ-011 Port busy, output, 1 bit; a check is in progress.
REQ-012 Port done, output, 1 bit; a check is complete, held high until the next start or reset.
REQ-013 Port success, output, 1 bit; the grid is valid, meaningful only while done=1.
REQ-014 Port err_index, output, IW bits; row-major index of the first offending cell.

Function
REQ-015 The FSM SHALL have the states IDLE, RECV and DONE.
REQ-016 In IDLE, start=1 SHALL clear all bookkeeping and move the FSM to RECV on the next edge.
REQ-017 In DONE, start=1 SHALL clear all bookkeeping and move the FSM to RECV on the next edge.
REQ-018 In RECV, start=1 SHALL abort the grid in progress, clear all bookkeeping and remain in RECV with the cell index at 0.
REQ-019 When start=1 and a handshake occur in the same cycle, start SHALL win and the cell SHALL be discarded.
REQ-020 in_ready SHALL be 1 only in RECV; busy SHALL equal (state==RECV).
REQ-021 A cell SHALL be accepted when in_valid=1 and in_ready=1, and in_valid=0 cycles SHALL stall the checker without changing any state.
REQ-022 Cells SHALL arrive in row-major order, with index 0..AREA-1.
REQ-023 Row, column and block position SHALL be held in wrap-around counters (col 0..LENGTH-1, row 0..LENGTH-1, block row and column 0..ORDER-1), with no division or modulo logic.
REQ-024 The checker SHALL hold LENGTH-bit seen-bitmaps: LENGTH for rows, LENGTH for columns and LENGTH for blocks.
REQ-025 An accepted cell SHALL be an offence if in_value is not exactly one-hot (zero or multi-hot).
REQ-026 An accepted cell SHALL be an offence if in_value AND the seen-bitmap of its row, column or block is nonzero.
REQ-027 Every accepted cell SHALL OR its in_value into its row, column and block bitmaps, including offending cells.
REQ-028 The first offence SHALL latch err_index to the cell index and set a sticky error flag, and later offences SHALL not change err_index.
REQ-029 After an offence, the checker SHALL keep consuming cells through index AREA-1, so upstream never deadlocks.
REQ-030 Acceptance of cell AREA-1 SHALL move the FSM to DONE, with done=1 on the following cycle (latency 1 cycle).
REQ-031 On entry to DONE, success SHALL equal NOT(error flag).
REQ-032 err_index SHALL read 0 whenever success=1.
REQ-033 done, success and err_index SHALL remain stable in DONE until start or reset.
REQ-034 done and success SHALL clear in the cycle after start is sampled.
REQ-035 All outputs SHALL be registered, with no combinational path from in_value to done, success or err_index.

Reset
REQ-036 reset=0 SHALL asynchronously force state=IDLE, clear all bitmaps, counters and the error flag, and drive in_ready=0, busy=0, done=0, success=0, err_index=0.
REQ-037 reset asserted mid-grid SHALL discard all partial results, and the checker SHALL require a new start after release.
REQ-038 Release of reset SHALL take effect on the first clock edge at which reset=1, with no output change until start.

Verification (ORDER=3)
REQ-039 Valid grid, cell (r,c) = one-hot of ((3*(r%3)+r/3+c)%9), in_valid always 1 -> done=1 one cycle after cell 80, success=1, err_index=0.
REQ-040 Valid grid with in_valid toggling 1,0,0,1,... -> same result as REQ-039, with exactly 81 accepted handshakes.
REQ-041 Row duplicate: cell 1 = cell 0 value, further duplicates at 30 and 50 -> done=1, success=0, err_index=1.
REQ-042 Column duplicate at cell 9 only -> success=0, err_index=9; block-only duplicate (cell 10 = cell 0, with no row or column clash) -> err_index=10.
REQ-043 Cell 40 = 9'b0 or 9'b000000011 -> success=0, err_index=40.
REQ-044 reset=0 at cell 37 -> all outputs 0 immediately; start followed by a valid grid -> success=1.
REQ-045 start=1 at cell 20 during an erroring grid -> error cleared, and a fresh valid grid -> success=1.
